// File: rtl/signed_sar_search_if.sv
// Start/done handshake plus comparator relation signals of the signed SAR engine.
// master = the search engine (drives probe, consumes the g/l/e verdict).
interface signed_sar_search_if;
    logic        start;
    logic        cmp_g;
    logic        cmp_l;
    logic        cmp_e;
    logic [15:0] probe;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  steps;
    logic        err;

    modport master (
        input  start, cmp_g, cmp_l, cmp_e,
        output probe, busy, done, result, steps, err
    );

    modport slave (
        output start, cmp_g, cmp_l, cmp_e,
        input  probe, busy, done, result, steps, err
    );
endinterface

// File: rtl/signed_sar_search.sv
// Signed SAR search over an external comparator; done at 16*(1+CMP_LAT)+1 cycles after start.
// Build option SAR_EARLY_EXIT_EN: an equal verdict finishes the search at once.
module signed_sar_search #(
    parameter int CMP_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    signed_sar_search_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_WAIT, S_FIN} state_t;

    localparam logic [15:0] SIGN      = 16'h8000;
    localparam logic [2:0]  LAST_WAIT = 3'((CMP_LAT == 0) ? 0 : CMP_LAT - 1);

    state_t      state, state_nxt;
    logic [15:0] acc, acc_nxt, trial, trial_nxt;
    logic [15:0] probe_q, result_q;
    logic [4:0]  steps_q;
    logic [3:0]  bit_idx;
    logic [2:0]  cnt;
    logic        err_q;
    logic        sample, bad, hit, fin_now;

    // Search runs on u = value ^ 0x8000 so an unsigned SAR equals a signed search.
    assign trial     = acc | (16'h0001 << bit_idx);
    assign acc_nxt   = bus.cmp_g ? acc : trial;
    assign trial_nxt = acc_nxt | (16'h0001 << (bit_idx - 4'd1));

    assign bad = ({bus.cmp_g, bus.cmp_l, bus.cmp_e} != 3'b100) &&
                 ({bus.cmp_g, bus.cmp_l, bus.cmp_e} != 3'b010) &&
                 ({bus.cmp_g, bus.cmp_l, bus.cmp_e} != 3'b001);

`ifdef SAR_EARLY_EXIT_EN
    assign hit = bus.cmp_e;
`else
    assign hit = 1'b0;
`endif

    assign fin_now = bad || hit || (bit_idx == 4'd0);

    // The verdict is sampled in the last cycle of each probe window.
    assign sample = ((state == S_PROBE) && (CMP_LAT == 0)) ||
                    ((state == S_WAIT) && (cnt == LAST_WAIT));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_PROBE;
            S_PROBE: begin
                if (CMP_LAT != 0) state_nxt = S_WAIT;
                else              state_nxt = fin_now ? S_FIN : S_PROBE;
            end
            S_WAIT:  if (sample) state_nxt = fin_now ? S_FIN : S_PROBE;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_PROBE) || (state == S_WAIT);
        bus.done = (state == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            probe_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && bus.start) begin
                acc     <= '0;
                bit_idx <= 4'd15;
                probe_q <= 16'h0000;
                steps_q <= '0;
                err_q   <= 1'b0;
            end
            if (state == S_WAIT) cnt <= cnt + 3'd1;
            else                 cnt <= '0;
            if (sample) begin
                steps_q <= steps_q + 5'd1;
                if (bad) begin
                    err_q    <= 1'b1;
                    result_q <= acc ^ SIGN;
                end else if (hit) begin
                    acc      <= trial;
                    result_q <= probe_q;
                end else begin
                    acc <= acc_nxt;
                    if (bit_idx == 4'd0) begin
                        result_q <= acc_nxt ^ SIGN;
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                        probe_q <= trial_nxt ^ SIGN;
                    end
                end
            end
        end
    end

    assign bus.probe  = probe_q;
    assign bus.result = result_q;
    assign bus.steps  = steps_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_signed_sar_search.sv
// Bench for signed_sar_search: three instances (CMP_LAT 0/2/3) each facing a delayed comparator model.
module tb_signed_sar_search;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [15:0] result;
        logic [4:0]  steps;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] probe_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        start_i   [3];
    logic        force_bad [3];
    logic [15:0] tgt       [3];
    logic [15:0] probe_o   [3];
    logic [15:0] result_o  [3];
    logic [4:0]  steps_o   [3];
    logic        busy_o    [3];
    logic        done_o    [3];
    logic        err_o     [3];

    signed_sar_search_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 0 : g + 1;
        localparam int HI  = (LAT == 0) ? 0 : LAT - 1;
        logic [15:0] hist [8];
        logic [15:0] seen;

        signed_sar_search #(.CMP_LAT(LAT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );

        // Comparator whose relation lags the probe by LAT cycles.
        always @(posedge clk) begin
            hist[0] <= bus[g].probe;
            for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
        end
        assign seen = (LAT == 0) ? bus[g].probe : hist[HI];

        assign bus[g].start = start_i[g];
        assign bus[g].cmp_g = force_bad[g] | ($signed(seen) > $signed(tgt[g]));
        assign bus[g].cmp_l = force_bad[g] | ($signed(seen) < $signed(tgt[g]));
        assign bus[g].cmp_e = ~force_bad[g] & (seen == tgt[g]);
        assign probe_o[g]  = bus[g].probe;
        assign result_o[g] = bus[g].result;
        assign steps_o[g]  = bus[g].steps;
        assign busy_o[g]   = bus[g].busy;
        assign done_o[g]   = bus[g].done;
        assign err_o[g]    = bus[g].err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int i);
        chk("rst_probe",  {16'd0, probe_o[i]}, 32'd0);
        chk("rst_result", {16'd0, result_o[i]}, 32'd0);
        chk("rst_steps",  {27'd0, steps_o[i]}, 32'd0);
        chk("rst_busy",   {31'd0, busy_o[i]}, 32'd0);
        chk("rst_done",   {31'd0, done_o[i]}, 32'd0);
        chk("rst_err",    {31'd0, err_o[i]}, 32'd0);
    endtask

    // Reference search in the signed domain: grow the largest value known to be <= target.
    task automatic build_expect(input int lat, input logic [15:0] t, input int bad_at);
        int   val, trial, n, ts;
        bit   stop;
        exp_t x;
        ts = int'($signed(t));
        val = -32768; n = 0; stop = 1'b0; x.err = 1'b0;
        for (int k = 15; k >= 0 && !stop; k--) begin
            trial = val + (1 << k);
            probe_q.push_back(16'(trial));
            n++;
            if (n == bad_at) begin
                x.err = 1'b1; stop = 1'b1;
            end else if (EARLY && trial == ts) begin
                val = trial; stop = 1'b1;
            end else if (trial <= ts) begin
                val = trial;
            end
        end
        x.result = 16'(val);
        x.steps  = 5'(n);
        x.cycle  = n * (1 + lat) + 1;
        exp_q.push_back(x);
    endtask

    task automatic run_search(input int i, input logic [15:0] t, input int bad_at, input int extra_start);
        int          lat, w, c;
        bit          seen_done;
        exp_t        x;
        logic [15:0] ep;
        lat = (i == 0) ? 0 : i + 1;
        tgt[i] = t;
        build_expect(lat, t, bad_at);
        start_i[i] = 1'b1;
        @(posedge clk); #1;
        start_i[i] = 1'b0;
        seen_done = 1'b0;
        for (c = 1; c <= 16 * (1 + lat) + 4 && !seen_done; c++) begin
            w = (c - 1) / (1 + lat);
            start_i[i]   = (c == extra_start);
            force_bad[i] = (bad_at > 0) && (w == bad_at - 1);
            if (c == 1) chk("err_cleared", {31'd0, err_o[i]}, 32'd0);
            if (done_o[i]) begin
                seen_done = 1'b1;
                x = exp_q.pop_front();
                chk("done_cycle", c, x.cycle);
                chk("result", {16'd0, result_o[i]}, {16'd0, x.result});
                chk("steps", {27'd0, steps_o[i]}, {27'd0, x.steps});
                chk("err", {31'd0, err_o[i]}, {31'd0, x.err});
                chk("busy_at_done", {31'd0, busy_o[i]}, 32'd0);
            end else begin
                chk("busy", {31'd0, busy_o[i]}, 32'd1);
                if ((c - 1) % (1 + lat) == 0 && probe_q.size() > 0) begin
                    ep = probe_q.pop_front();
                    chk("probe", {16'd0, probe_o[i]}, {16'd0, ep});
                end
                @(posedge clk); #1;
            end
        end
        start_i[i]   = 1'b0;
        force_bad[i] = 1'b0;
        chk("done_seen", {31'd0, seen_done}, 32'd1);
        chk("probes_left", probe_q.size(), 32'd0);
        probe_q.delete();
        if (!seen_done) exp_q.delete();
        else begin
            @(posedge clk); #1;
            chk("done_pulse", {31'd0, done_o[i]}, 32'd0);
            chk("idle_busy", {31'd0, busy_o[i]}, 32'd0);
        end
    endtask

    initial begin
        int saw_done;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0; force_bad[i] = 1'b0; tgt[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) chk_reset(i);

        run_search(0, 16'h0000, 0, 0);
        run_search(0, 16'h8000, 0, 0);
        run_search(1, 16'h7FFF, 0, 0);
        run_search(0, 16'hFFFF, 0, 0);
        run_search(2, 16'hFFFF, 0, 0);
        run_search(0, 16'h1234, 3, 0);
        run_search(0, 16'h1234, 0, 0);
        run_search(2, 16'hC3A5, 3, 0);
        run_search(2, 16'hC3A5, 0, 0);
        run_search(0, 16'h1234, 0, 8);
        run_search(0, 16'h8000, 0, 17);

        // Reset in cycle 5 of a search: outputs return to reset values, no done.
        tgt[0] = 16'h5555;
        start_i[0] = 1'b1;
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset(0);
        saw_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_o[0]) saw_done++;
        end
        chk("no_done_after_rst", saw_done, 32'd0);
        chk("idle_after_rst", {31'd0, busy_o[0]}, 32'd0);

        for (int k = 0; k < 1000; k++) run_search(0, 16'($urandom), 0, 0);
        for (int k = 0; k < 1000; k++) run_search(2, 16'($urandom), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/signed_sar_search.md
# signed_sar_search

Sequential successive-approximation engine that drives the probe operand of an external 16-bit two's-complement comparator and uses its g/l/e relation to recover an unknown signed target held on the comparator's other operand. It is the initiator side of the comparator relation interface. The block issues probes, consumes the comparator's verdicts, and reports the recovered value with a start/done handshake. It sits beside the signed comparator in the datapath: the comparator's A input is wired to `probe`, and its B input is the target.

## Interface
Parameters:
- `CMP_LAT`, default 0: number of extra cycles between a probe change and a valid relation on `cmp_g/cmp_l/cmp_e`. Legal range is 0..7.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  single-cycle request to begin a search; sampled only in IDLE.
- `cmp_g`  in  1  comparator verdict: probe > target (signed).
- `cmp_l`  in  1  comparator verdict: probe < target (signed).
- `cmp_e`  in  1  comparator verdict: probe == target.
- `probe`  out  16  registered trial value driven to the comparator.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse; `result`, `steps` and `err` are valid from this cycle onward.
- `result`  out  16  recovered signed target; held until the next accepted `start`.
- `steps`  out  5  number of probes evaluated (1..16).
- `err`  out  1  high if a verdict was not one-hot; held until the next accepted `start`.

## Operation
- The search runs in the offset domain `u = value ^ 16'h8000`, so that an unsigned SAR over `u` equals a signed search. The accumulator `acc` (16 bits) clears to 0 at `start`.
- For bit k = 15 down to 0:
  - trial = `acc | (1<<k)`; `probe = trial ^ 16'h8000`.
  - On the sampled verdict: `cmp_g` means drop bit k (acc unchanged); `cmp_l` or `cmp_e` means keep bit k (acc = trial).
- The first probe is always 0x0000 (signed 0).
- Final `result = acc ^ 16'h8000` = the largest probe ≤ target, which is the target itself.
- Verdict check: at every sample, exactly one of g/l/e must be high. Otherwise the search aborts: `err`=1, `done` pulses, and `result` = current `acc ^ 16'h8000`.
- States:
  - IDLE: wait for `start`.
  - PROBE: load `probe`, reset the wait counter.
  - WAIT: count `CMP_LAT` cycles.
  - EVAL: sample the verdict and update `acc`/`steps`.
  - FIN: pulse `done`, return to IDLE.
- State transitions:
  - IDLE→PROBE on `start`.
  - PROBE→WAIT if `CMP_LAT`>0, else PROBE/EVAL merge: the sample is taken in the same cycle the probe is visible.
  - WAIT→EVAL after `CMP_LAT` cycles.
  - EVAL→PROBE (next bit), or →FIN after bit 0, on an early exit, or on an error.
- `start` while busy: ignored; the search in progress is unaffected.
- `start` in the same cycle as FIN/`done`: ignored; a new request must be issued from IDLE.
- Reset values: `probe`=0x0000, `result`=0x0000, `steps`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Reset mid-search: the search is abandoned at the next edge, all outputs return to their reset values, and no `done` pulse is produced.

## Timing
- `start` is sampled at edge 0. `busy`=1 and the first `probe` are valid in cycle 1.
- Each probe is held for 1+`CMP_LAT` cycles. The verdict is sampled in the last cycle of that window.
- The next probe appears in the cycle after the sample. `done` pulses in the cycle after the final sample, and `busy` drops in that same cycle.
- Full search: `done` at cycle 16·(1+`CMP_LAT`)+1. With `CMP_LAT`=0 this is cycle 17.
- `probe` holds its last value while in IDLE.

## Configuration
- `SAR_EARLY_EXIT_EN` defined: a sampled `cmp_e` ends the search immediately. `result` = the current probe, `steps` = the probes used so far, and the machine goes to FIN.
- `SAR_EARLY_EXIT_EN` undefined: `cmp_e` is treated as keep-bit only. All 16 probes always run and `steps` is always 16.

## Test plan
- Target 0x0000, `CMP_LAT`=0, early exit enabled → first probe 0x0000, `cmp_e`; `done` at cycle 2; `result`=0x0000, `steps`=1, `err`=0. With early exit disabled → `done` at cycle 17, `result`=0x0000, `steps`=16.
- Target 0x8000 (−32768) → the probe sequence starts 0x0000, 0xC000, 0xA000…; every verdict is g; `result`=0x8000, `steps`=16, `done` at cycle 17.
- Target 0x7FFF, `CMP_LAT`=2 → every verdict is l until the last probe 0x7FFF returns e; `result`=0x7FFF, `steps`=16, `done` at cycle 49.
- Target 0xFFFF (−1) and a sweep of 1000 random targets, with both `CMP_LAT`=0 and `CMP_LAT`=3 → `result` equals the target every time, `err`=0, and the probe sequence matches the reference SAR model.
- Forced verdict g=l=1 on the third sample → `done` one cycle later, `err`=1, `steps`=3, `busy`=0; the next `start` clears `err`.
- `rst` asserted in cycle 5 of a search → from the next edge all outputs are at reset values and no `done` pulse occurs. A `start` pulse in cycle 8 of a search is ignored, and that search still completes normally.
